// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch port (IF) and a
// data-memory port (DM). A three-state FSM (IDLE -> WAIT -> RESP) grants one requester,
// holds its command on the memory port until mem_ack or a timeout, then returns a one-cycle
// response to that requester. All outputs are registered.
//
// Parameter : TIMEOUT  WAIT cycles without mem_ack before an error response (1..255)
// Macro     : ARB_ROUND_ROBIN_EN  defined -> alternate owners on contention;
//                                 undefined -> DM always wins contention
// Ports     : clk, rst_n (async, active-low)
//             if_req/if_addr  -> if_gnt/if_rvalid/if_rdata      fetch side
//             dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt/dm_rvalid/dm_rdata  data side
//             mem_req/mem_we/mem_addr/mem_wdata -> memory, mem_ack/mem_rdata <- memory
//             resp_err (timeout flag alongside rvalid), busy (state != IDLE)

module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state, w_state_d;
    logic [7:0]  r_cnt, w_cnt_d;
    logic        r_owner, w_owner_d;          // 1 = DM owns the current transaction
    logic        r_if_gnt, w_if_gnt_d;
    logic        r_dm_gnt, w_dm_gnt_d;
    logic        r_if_rvalid, w_if_rvalid_d;
    logic        r_dm_rvalid, w_dm_rvalid_d;
    logic [31:0] r_if_rdata, w_if_rdata_d;
    logic [31:0] r_dm_rdata, w_dm_rdata_d;
    logic        r_mem_req, w_mem_req_d;
    logic        r_mem_we, w_mem_we_d;
    logic [31:0] r_mem_addr, w_mem_addr_d;
    logic [31:0] r_mem_wdata, w_mem_wdata_d;
    logic        r_resp_err, w_resp_err_d;
    logic        r_busy, w_busy_d;

    logic        w_req_any;
    logic        w_pick_dm;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;

    assign w_req_any = if_req | dm_req;
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == TimeoutCnt);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_dm;

    // On contention the requester that did not own the last grant wins.
    assign w_pick_dm = dm_req & (~if_req | ~r_last_dm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_dm <= 1'b0;
        end else if (r_state == StIdle && w_req_any) begin
            r_last_dm <= w_pick_dm;
        end
    end
`else
    assign w_pick_dm = dm_req;
`endif

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 8'd0;
            r_owner     <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_dm_rdata  <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_resp_err  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_owner     <= w_owner_d;
            r_if_gnt    <= w_if_gnt_d;
            r_dm_gnt    <= w_dm_gnt_d;
            r_if_rvalid <= w_if_rvalid_d;
            r_dm_rvalid <= w_dm_rvalid_d;
            r_if_rdata  <= w_if_rdata_d;
            r_dm_rdata  <= w_dm_rdata_d;
            r_mem_req   <= w_mem_req_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_resp_err  <= w_resp_err_d;
            r_busy      <= w_busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_req_any) w_state_d = StWait;
            StWait:  if (mem_ack || w_timeout) w_state_d = StResp;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        logic        rsp_fire;
        logic [31:0] rsp_data;
        logic        rsp_err;

        rsp_fire      = 1'b0;
        rsp_data      = 32'h0;
        rsp_err       = 1'b0;
        w_cnt_d       = r_cnt;
        w_owner_d     = r_owner;
        w_if_gnt_d    = 1'b0;
        w_dm_gnt_d    = 1'b0;
        w_if_rvalid_d = 1'b0;
        w_dm_rvalid_d = 1'b0;
        w_if_rdata_d  = r_if_rdata;
        w_dm_rdata_d  = r_dm_rdata;
        w_mem_we_d    = r_mem_we;
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
        w_mem_req_d   = (w_state_d == StWait);
        w_busy_d      = (w_state_d != StIdle);

        case (r_state)
            StIdle: begin
                if (w_req_any) begin
                    w_owner_d     = w_pick_dm;
                    w_cnt_d       = 8'd0;
                    w_mem_addr_d  = w_pick_dm ? dm_addr : if_addr;
                    w_mem_we_d    = w_pick_dm & dm_we;
                    w_mem_wdata_d = w_pick_dm ? dm_wdata : 32'h0;
                    w_if_gnt_d    = ~w_pick_dm;
                    w_dm_gnt_d    = w_pick_dm;
                end
            end
            StWait: begin
                // mem_ack wins over a timeout reached on the same edge
                if (mem_ack) begin
                    rsp_fire = 1'b1;
                    rsp_data = r_mem_we ? 32'h0 : mem_rdata;
                    w_cnt_d  = 8'd0;
                end else if (w_timeout) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    w_cnt_d  = 8'd0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            default: ;
        endcase

        if (rsp_fire) begin
            w_resp_err_d = rsp_err;
            if (r_owner) begin
                w_dm_rvalid_d = 1'b1;
                w_dm_rdata_d  = rsp_data;
            end else begin
                w_if_rvalid_d = 1'b1;
                w_if_rdata_d  = rsp_data;
            end
        end else begin
            w_resp_err_d = 1'b0;
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_gnt    = r_dm_gnt;
    assign dm_rvalid = r_dm_rvalid;
    assign dm_rdata  = r_dm_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign resp_err  = r_resp_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: expected responses are queued when a request is issued and
// popped/compared when an rvalid appears. Inputs change at the falling edge, outputs are
// sampled at the falling edge.

module tb_mem_port_arbiter;

    localparam int unsigned TO = 16;

    typedef struct packed {
        logic        dm;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic        mem_req, mem_we, resp_err, busy;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    rsp_t q_exp[$];
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    // Waits up to max_cyc falling edges for a grant; g = {if_gnt, dm_gnt}, 0 if none.
    task automatic wait_gnt(input int max_cyc, output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (if_gnt || dm_gnt) begin
                g = {if_gnt, dm_gnt};
                break;
            end
        end
    endtask

    // Looks at the current falling edge first, then waits for an rvalid.
    task automatic wait_rvalid(input int max_cyc, output bit seen, output rsp_t got);
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < max_cyc; i++) begin
            if (if_rvalid || dm_rvalid) begin
                seen     = 1'b1;
                got.dm   = dm_rvalid;
                got.data = dm_rvalid ? dm_rdata : if_rdata;
                got.err  = resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [135:0] outs;
        apply_reset();
        rst_n = 1'b0;
        #1;
        outs = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_req, mem_we,
                mem_addr, mem_wdata, resp_err, busy};
        n_total++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy, mem_req} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_idle: busy/mem_req got %b want 00", {busy, mem_req});
        end
    endtask

    task automatic test_fetch();
        logic [1:0] g;
        bit         seen;
        rsp_t       got, exp;
        if_req = 1'b1; if_addr = 32'h0000_0004;
        q_exp.push_back('{dm: 1'b0, data: 32'h2402_0000, err: 1'b0});
        wait_gnt(4, g);
        if_req = 1'b0;
        n_total++;
        if (g !== 2'b10) begin
            n_bad++;
            $display("FAIL fetch_gnt: got %b want 10", g);
        end
        n_total++;
        if ({mem_req, mem_we, mem_addr, busy} !== {1'b1, 1'b0, 32'h4, 1'b1}) begin
            n_bad++;
            $display("FAIL fetch_cmd: req/we/addr/busy got %b %b %h %b want 1 0 4 1",
                     mem_req, mem_we, mem_addr, busy);
        end
        @(negedge clk);
        n_total++;
        if ({if_gnt, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h4}) begin
            n_bad++;
            $display("FAIL fetch_wait2: gnt/req/addr got %b %b %h want 0 1 4",
                     if_gnt, mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h2402_0000;
        @(negedge clk);
        mem_ack = 1'b0;
        wait_rvalid(4, seen, got);
        exp = q_exp.pop_front();
        n_total++;
        if (!seen || got !== exp) begin
            n_bad++;
            $display("FAIL fetch_rsp: seen=%0b got %h want %h", seen, got, exp);
        end
        @(negedge clk);
        n_total++;
        if ({if_rvalid, dm_rvalid, resp_err, busy, if_rdata} !== {4'b0000, 32'h2402_0000}) begin
            n_bad++;
            $display("FAIL fetch_after: rv/rv/err/busy/rdata got %b%b%b%b %h want 0000 24020000",
                     if_rvalid, dm_rvalid, resp_err, busy, if_rdata);
        end
    endtask

    task automatic test_write();
        logic [1:0] g;
        bit         seen;
        rsp_t       got, exp;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        q_exp.push_back('{dm: 1'b1, data: 32'h0, err: 1'b0});
        wait_gnt(4, g);
        dm_req = 1'b0; dm_we = 1'b0;
        n_total++;
        if (g !== 2'b01) begin
            n_bad++;
            $display("FAIL write_gnt: got %b want 01", g);
        end
        n_total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h100, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL write_cmd: req/we/addr/wdata got %b%b %h %h want 11 100 deadbeef",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        wait_rvalid(4, seen, got);
        exp = q_exp.pop_front();
        n_total++;
        if (!seen || got !== exp) begin
            n_bad++;
            $display("FAIL write_rsp: seen=%0b got %h want %h", seen, got, exp);
        end
        n_total++;
        if ({if_rvalid, if_rdata, mem_req} !== {1'b0, 32'h2402_0000, 1'b0}) begin
            n_bad++;
            $display("FAIL write_nonowner: if_rvalid/if_rdata/mem_req got %b %h %b want 0 24020000 0",
                     if_rvalid, if_rdata, mem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [1:0] g, g_exp;
        bit         seen;
        rsp_t       got, exp;
        logic       exp_dm;
        apply_reset();
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_dm = (i % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            g_exp = exp_dm ? 2'b01 : 2'b10;
            q_exp.push_back('{dm: exp_dm, data: 32'hA000_0000 + i, err: 1'b0});
            wait_gnt(5, g);
            n_total++;
            if (g !== g_exp || mem_addr !== (exp_dm ? 32'h80 : 32'h40)) begin
                n_bad++;
                $display("FAIL contend_gnt%0d: gnt %b addr %h want %b %h", i, g, mem_addr,
                         g_exp, exp_dm ? 32'h80 : 32'h40);
            end
            mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + i;
            @(negedge clk);
            mem_ack = 1'b0;
            wait_rvalid(4, seen, got);
            exp = q_exp.pop_front();
            n_total++;
            if (!seen || got !== exp) begin
                n_bad++;
                $display("FAIL contend_rsp%0d: seen=%0b got %h want %h", i, seen, got, exp);
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [1:0] g;
        bit         seen;
        rsp_t       got, exp;
        int         n_wait;
        if_req = 1'b1; if_addr = 32'h200;
        q_exp.push_back('{dm: 1'b0, data: 32'h0, err: 1'b1});
        wait_gnt(5, g);
        if_req = 1'b0;
        n_wait = 0;
        for (int i = 0; i < 40; i++) begin
            if (if_rvalid || dm_rvalid) break;
            if (mem_req) n_wait++;
            @(negedge clk);
        end
        n_total++;
        if (n_wait != TO || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d mem_req=%b want %0d 0", n_wait, mem_req, TO);
        end
        wait_rvalid(1, seen, got);
        exp = q_exp.pop_front();
        n_total++;
        if (!seen || got !== exp) begin
            n_bad++;
            $display("FAIL timeout_rsp: seen=%0b got %h want %h", seen, got, exp);
        end
        @(negedge clk);
        // Ack arrives on exactly the edge the timeout would fire
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        q_exp.push_back('{dm: 1'b1, data: 32'h5555_AAAA, err: 1'b0});
        wait_gnt(5, g);
        dm_req = 1'b0;
        repeat (TO - 1) @(negedge clk);
        n_total++;
        if ({mem_req, if_rvalid | dm_rvalid} !== 2'b10) begin
            n_bad++;
            $display("FAIL timeout_edge_wait: mem_req/rvalid got %b%b want 10",
                     mem_req, if_rvalid | dm_rvalid);
        end
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_ack = 1'b0;
        wait_rvalid(2, seen, got);
        exp = q_exp.pop_front();
        n_total++;
        if (!seen || got !== exp) begin
            n_bad++;
            $display("FAIL timeout_edge_rsp: seen=%0b got %h want %h", seen, got, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        logic [1:0]   g;
        logic [135:0] outs;
        bit           seen;
        rsp_t         got, exp;
        int           n_rv;
        if_req = 1'b1; if_addr = 32'h500;
        wait_gnt(5, g);
        if_req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        outs = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_req, mem_we,
                mem_addr, mem_wdata, resp_err, busy};
        n_total++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL midreset_async: got %h want 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_rv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_rvalid || dm_rvalid || busy) n_rv++;
        end
        n_total++;
        if (n_rv != 0) begin
            n_bad++;
            $display("FAIL midreset_quiet: rvalid/busy cycles got %0d want 0", n_rv);
        end
        if_req = 1'b1; if_addr = 32'h8;
        q_exp.push_back('{dm: 1'b0, data: 32'hCAFE_F00D, err: 1'b0});
        wait_gnt(5, g);
        if_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
        wait_rvalid(4, seen, got);
        exp = q_exp.pop_front();
        n_total++;
        if (!seen || got !== exp || g !== 2'b10) begin
            n_bad++;
            $display("FAIL midreset_resume: seen=%0b gnt %b got %h want 10 %h", seen, g, got, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_idle_ack();
        int n_bad_cyc;
        n_bad_cyc = 0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy || mem_req || if_rvalid || dm_rvalid) n_bad_cyc++;
        end
        mem_ack = 1'b0;
        @(negedge clk);
        n_total++;
        if (n_bad_cyc != 0 || if_rdata !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL idle_ack: active cycles %0d if_rdata %h want 0 cafef00d",
                     n_bad_cyc, if_rdata);
        end
        n_total++;
        if (q_exp.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got %0d left want 0", q_exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_contention();
        test_timeout();
        test_reset_mid_wait();
        test_idle_ack();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
